// File: rtl/nibble_serial_sub16.sv
// Nibble-serial subtractor: a - b - bin, one 4-bit lookahead slice per cycle,
// LS nibble first, with borrow/overflow/zero flags published on completion.
module nibble_serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [3:0]       w_an;
    logic [3:0]       w_bn;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;
    logic [WIDTH-1:0] w_acc_nx;
    logic             w_last;
    logic             w_accept;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_state == RUN) && (r_cnt == CW'(NIB - 1));

    // Subtraction as a + ~b + c, generate/propagate on the inverted subtrahend
    assign w_an = r_a[{r_cnt, 2'b00} +: 4];
    assign w_bn = ~r_b[{r_cnt, 2'b00} +: 4];
    assign w_g  = w_an & w_bn;
    assign w_p  = w_an ^ w_bn;

    assign w_c[0] = r_c;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2])
                  | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum  = w_p ^ w_c[3:0];

    always_comb begin
        w_acc_nx = r_acc;
        w_acc_nx[{r_cnt, 2'b00} +: 4] = w_sum;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nx = RUN;
            RUN:     if (w_last) w_state_nx = DONE;
            DONE:    w_state_nx = start ? RUN : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Partial nibbles live in r_acc; diff only moves on the final nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= ~bin;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_c   <= w_c[4];
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_acc_nx;
            if (w_last) begin
                r_diff <= w_acc_nx;
                r_bout <= ~w_c[4];
                r_ovf  <= (r_a[MSB] != r_b[MSB]) &&
                          (w_acc_nx[MSB] != r_a[MSB]);
                r_zero <= (w_acc_nx == '0);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Bench for nibble_serial_sub16: directed table, multi-cycle corner
// sequences and back-to-back random operations against an integer model.
module tb_nibble_serial_sub16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    nibble_serial_sub16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned and signed views
    task automatic model(input logic [15:0] x, input logic [15:0] y,
                         input logic c, output logic [15:0] d,
                         output logic bo, output logic ov,
                         output logic z);
        int r;
        int s;
        r  = int'(x) - int'(y) - int'(c);
        s  = int'($signed(x)) - int'($signed(y)) - int'(c);
        d  = r[15:0];
        bo = (r < 0);
        ov = (s < -32768) || (s > 32767);
        z  = (d == 16'h0000);
    endtask

    // Start one op; with keep=1 start stays high and inputs get scrambled
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tbin, input logic [15:0] ed,
                          input logic eb, input logic eo, input logic ez,
                          input bit keep, output int dcyc);
        int lat;
        int bcnt;
        a     = ta;
        b     = tb_;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (keep) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
        end else begin
            start = 1'b0;
        end
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        dcyc = cyc;
        chk("latency", lat, 4);
        chk("busy_cycles", bcnt, 4);
        chk("diff", int'(diff), int'(ed));
        chk("bout", int'(bout), int'(eb));
        chk("ovf", int'(ovf), int'(eo));
        chk("zero", int'(zero), int'(ez));
    endtask

    vec_t        tbl[$];
    logic [15:0] md;
    logic        mb, mo, mz;
    logic [15:0] ra, rb;
    logic        rc;
    int          d0, d1;
    bit          saw;

    initial begin
        tbl.push_back('{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{16'hABCD, 16'hABCD, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16'hF00F, 16'h0FF0, 1'b1, 16'hE01E, 1'b0, 1'b0, 1'b0});

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_flags", int'({bout, ovf, zero}), 0);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i])
            run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].diff,
                   tbl[i].bout, tbl[i].ovf, tbl[i].zero, 1'b0, d0);

        // Inputs changing during RUN are ignored; start held in DONE
        run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0,
               1'b1, d0);
        run_op(16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0,
               1'b0, d1);
        chk("b2b_gap", d1 - d0, 5);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the 2nd RUN cycle aborts with no later done
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0,
               1'b0, d0);
        a     = 16'h1111;
        b     = 16'h0001;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_diff", int'(diff), 0);
        chk("abort_flags", int'({bout, ovf, zero}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1'b1;
        end
        chk("abort_no_done", int'(saw), 0);
        run_op(16'h1111, 16'h0001, 1'b0, 16'h1110, 1'b0, 1'b0, 1'b0,
               1'b0, d0);

        // Back-to-back random stream
        for (int i = 0; i < 5000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 16 == 0) rb = ra;
            model(ra, rb, rc, md, mb, mo, mz);
            run_op(ra, rb, rc, md, mb, mo, mz, 1'b1, d1);
            if (i > 0) chk("rnd_gap", d1 - d0, 5);
            d0 = d1;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
